// File: rtl/demux2_stream.sv
// Purpose : 1-to-2 stream demultiplexer; each destination owns a 2-entry FIFO.
// Latency : one cycle from an accepted input to that entry showing at an empty port.
// Backpr. : in_ready drops only when the queue picked by in_sel is full; pops still occur.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   in_data/in_sel/in_valid/in_ready  input stream, in_sel picks port 0 or 1
//   outN_data/outN_valid/outN_ready   output streams, data/valid straight from flops
//   cnt0/cnt1                       per-port pop counters, present only when the
//                                   macro DEMUX2_STREAM_CNT_EN is defined
//
// Parameters: WIDTH (payload bits), DEPTH (fixed at 2 entries per queue).

// Generic 2-entry FIFO: 1-bit read/write pointers and a 0..2 occupancy count.
// Head data and valid are registered; a push into an empty queue is visible next cycle.
// Push is refused while full, even if a pop happens in the same cycle.
module demux2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == 2'(DEPTH));
        rd_vld  = (count_q != 2'd0);
        rd_dat  = mem_q[rd_ptr_q];

        // Fullness is judged before the pop, so a full queue never accepts.
        do_push = wr_vld && !full;
        do_pop  = rd_rdy && rd_vld;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        // Simultaneous push and pop leaves the count untouched.
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; it is only observed while the count says valid.
    // A push during reset lands here but is harmless since the pointers restart at 0
    // with an empty count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

module demux2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
`ifdef DEMUX2_STREAM_CNT_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    input  logic             out1_ready
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // in_ready looks only at the selected queue, so a stalled port never blocks the other.
    always_comb begin
        in_ready = in_sel ? !full1 : !full0;
        push0    = in_valid && in_ready && !in_sel;
        push1    = in_valid && in_ready &&  in_sel;
    end

    demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q0 (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push0),
        .wr_dat (in_data),
        .full   (full0),
        .rd_vld (out0_valid),
        .rd_dat (out0_data),
        .rd_rdy (out0_ready)
    );

    demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q1 (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push1),
        .wr_dat (in_data),
        .full   (full1),
        .rd_vld (out1_valid),
        .rd_dat (out1_data),
        .rd_rdy (out1_ready)
    );

`ifdef DEMUX2_STREAM_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        cnt0_d = cnt0_q + {15'd0, (out0_valid && out0_ready)};
        cnt1_d = cnt1_q + {15'd0, (out1_valid && out1_ready)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios plus random traffic against a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The model keeps one SystemVerilog queue per port and applies push/pop rules per edge.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX2_STREAM_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    always #5 clk = ~clk;

    demux2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX2_STREAM_CNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .out1_ready (out1_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] m_cnt0 = 16'd0;
    logic [15:0] m_cnt1 = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every visible output with what the queue model says.
    task automatic check_outputs();
        chk("o0_vld", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        if (q0.size() != 0) chk("o0_dat", {24'd0, out0_data}, {24'd0, q0[0]});
        chk("o1_vld", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q1.size() != 0) chk("o1_dat", {24'd0, out1_data}, {24'd0, q1[0]});
        chk("in_rdy", {31'd0, in_ready},
            {31'd0, (in_sel ? q1.size() : q0.size()) < 2});
`ifdef DEMUX2_STREAM_CNT_EN
        chk("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
        chk("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
`endif
    endtask

    // One clock: drive, check on the falling edge, advance the model at the rising edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic r0, input logic r1, input logic rs);
        bit pop0, pop1, push;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        reset      = rs;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rs) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 16'd0;
            m_cnt1 = 16'd0;
        end else begin
            push = v && ((s ? q1.size() : q0.size()) < 2);
            pop0 = r0 && (q0.size() != 0);
            pop1 = r1 && (q1.size() != 0);
            if (pop0) begin void'(q0.pop_front()); m_cnt0 = m_cnt0 + 16'd1; end
            if (pop1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 16'd1; end
            if (push) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_o0_vld", {31'd0, out0_valid}, 32'd0);
        chk("rst_o1_vld", {31'd0, out1_valid}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_ready},   32'd1);

        // Single transfer to port 0 appears one cycle later
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        chk("lat_o0_vld", {31'd0, out0_valid}, 32'd1);
        chk("lat_o0_dat", {24'd0, out0_data},  32'h11);
        chk("lat_o1_vld", {31'd0, out1_valid}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill port 1 with its consumer stalled
        step(1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; in_sel = 1'b1; #1;
        chk("full_rdy_s1", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b0; #1;
        chk("full_rdy_s0", {31'd0, in_ready}, 32'd1);
        step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
        chk("p0_05_vld", {31'd0, out0_valid}, 32'd1);
        chk("p0_05_dat", {24'd0, out0_data},  32'h05);

        // Full port 1: push refused while a pop proceeds
        step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
        chk("refuse_dat", {24'd0, out1_data}, 32'hA2);
        in_sel = 1'b1; #1;
        chk("refuse_rdy", {31'd0, in_ready}, 32'd1);
        step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("order_A3", {24'd0, out1_data}, 32'hA3);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain1_vld", {31'd0, out1_valid}, 32'd0);

        // One entry on port 0; push and pop together
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
        chk("pp_vld", {31'd0, out0_valid}, 32'd1);
        chk("pp_dat", {24'd0, out0_data},  32'h22);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Both ports full, then reset with a push pending
        step(1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1);
        chk("mrst_o0_vld", {31'd0, out0_valid}, 32'd0);
        chk("mrst_o1_vld", {31'd0, out1_valid}, 32'd0);
        in_sel = 1'b0; #1;
        chk("mrst_rdy0", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1; #1;
        chk("mrst_rdy1", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

`ifdef DEMUX2_STREAM_CNT_EN
        // Drive cnt1 to 0xFFFF, then one more pop wraps it
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000 && m_cnt1 != 16'hFFFF; i++)
            step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
        chk("cnt1_max", {16'd0, cnt1}, 32'hFFFF);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("cnt1_wrap", {16'd0, cnt1}, 32'h0000);
        chk("cnt0_hold", {16'd0, cnt0}, 32'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
